// File: rtl/regwrite_trace.sv
`default_nettype none
// ============================================================================
//  Module      : regwrite_trace
//  Description : Timestamped FWFT trace FIFO of register-file write events;
//                r0 writes filtered, overflow counted, never back-pressures.
//  Revision    : 1.0 - initial release
// ============================================================================
module regwrite_trace #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CYC_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture_en,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_reg,
  output logic [DATA_W-1:0] out_data,
  output logic [CYC_W-1:0]  out_cycle,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [7:0]        overflow_cnt
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [4:0]        mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [CYC_W-1:0]  mem_cyc_q  [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic [CYC_W-1:0]  cycle_q,  cycle_d;
  logic [7:0]        ovf_q,    ovf_d;

  logic push_req, pop, push, drop, wr_en;

  always_comb begin
    push_req = capture_en & wb_en & (wb_reg != 5'd0);
    pop      = (count_q != '0) & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push     = push_req & ((count_q != c_depth) | pop);
    drop     = push_req & ~push;
    wr_en    = push & ~clear;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cycle_d  = cycle_q;
    ovf_d    = ovf_q;

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      cycle_d  = '0;
      ovf_d    = '0;
    end else begin
      cycle_d = cycle_q + CYC_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg_q[wr_ptr_q]  <= wb_reg;
      mem_data_q[wr_ptr_q] <= wb_data;
      mem_cyc_q[wr_ptr_q]  <= cycle_q;
    end
  end

  always_comb begin
    out_valid    = (count_q != '0);
    out_reg      = out_valid ? mem_reg_q[rd_ptr_q]  : '0;
    out_data     = out_valid ? mem_data_q[rd_ptr_q] : '0;
    out_cycle    = out_valid ? mem_cyc_q[rd_ptr_q]  : '0;
    count        = count_q;
    full         = (count_q == c_depth);
    overflow_cnt = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_regwrite_trace.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regwrite_trace
//  Description : Scoreboard bench for regwrite_trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regwrite_trace;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        capture_en = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [15:0] out_cycle;
  logic [4:0]  count;
  logic        full;
  logic [7:0]  overflow_cnt;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [15:0] c;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] tb_cyc;
  int          checks = 0;
  int          errors = 0;

  regwrite_trace #(.DEPTH(16), .ADDR_W(4), .DATA_W(32), .CYC_W(16)) dut (
    .clock(clock), .reset(reset), .clear(clear), .capture_en(capture_en),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg),
    .out_data(out_data), .out_cycle(out_cycle), .count(count), .full(full),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clock = ~clock;

  // Reference free-running timestamp.
  always @(posedge clock or negedge reset) begin
    if (!reset)     tb_cyc <= '0;
    else if (clear) tb_cyc <= '0;
    else            tb_cyc <= tb_cyc + 16'd1;
  end

  // Scoreboard: every accepted head entry must match the oldest expected event.
  always @(negedge clock) begin
    ev_t e;
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got reg=%0d data=%h cycle=%0d, required no entry",
                 out_reg, out_data, out_cycle);
      end else begin
        e = exp_q.pop_front();
        if (out_reg !== e.r || out_data !== e.d || out_cycle !== e.c) begin
          errors++;
          $display("FAIL scoreboard_entry: got reg=%0d data=%h cycle=%0d, required reg=%0d data=%h cycle=%0d",
                   out_reg, out_data, out_cycle, e.r, e.d, e.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wb(input logic [4:0] r, input logic [31:0] d,
                          input logic [15:0] stamp, input bit stored);
    wb_en   = 1'b1;
    wb_reg  = r;
    wb_data = d;
    if (stored) exp_q.push_back('{r: r, d: d, c: stamp});
  endtask

  task automatic idle_wb();
    wb_en   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 64) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out_valid, count, full, overflow_cnt, out_reg, out_data, out_cycle} !== '0) begin
      errors++;
      $display("FAIL reset_held: got valid=%b count=%0d full=%b ovf=%0d, required all 0",
               out_valid, count, full, overflow_cnt);
    end
    reset = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0 || overflow_cnt !== 8'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got valid=%b count=%0d full=%b ovf=%0d, required 0 0 0 0",
               out_valid, count, full, overflow_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive_wb(5'(i + 1), 32'hA000_0000 + i, 16'(i), 1'b1);
      tick();
    end
    idle_wb();
    drain("reset_stamps");
  endtask

  task automatic test_single_push();
    int n;
    n = 0;
    while (tb_cyc != 16'd10 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (tb_cyc != 16'd10) begin
      errors++;
      $display("FAIL single_wait: got cycle %0d, required 10", tb_cyc);
    end
    drive_wb(5'd5, 32'hDEADBEEF, 16'd10, 1'b1);
    tick();
    idle_wb();
    checks++;
    if (out_valid !== 1'b1 || out_reg !== 5'd5 || out_data !== 32'hDEADBEEF ||
        out_cycle !== 16'd10 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_push: got valid=%b reg=%0d data=%h cycle=%0d count=%0d, required 1 5 deadbeef 10 1",
               out_valid, out_reg, out_data, out_cycle, count);
    end
    tick();
    checks++;
    if (out_reg !== 5'd5 || out_data !== 32'hDEADBEEF || out_cycle !== 16'd10) begin
      errors++;
      $display("FAIL single_hold: got reg=%0d data=%h cycle=%0d, required 5 deadbeef 10",
               out_reg, out_data, out_cycle);
    end
    drain("single");
  endtask

  task automatic test_filter();
    drive_wb(5'd0, 32'h1111_1111, tb_cyc, 1'b0);
    tick();
    capture_en = 1'b0;
    drive_wb(5'd7, 32'h7777_7777, tb_cyc, 1'b0);
    tick();
    capture_en = 1'b1;
    idle_wb();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow_cnt !== 8'd0) begin
      errors++;
      $display("FAIL filter: got count=%0d valid=%b ovf=%0d, required 0 0 0",
               count, out_valid, overflow_cnt);
    end
  endtask

  task automatic test_overflow_and_full_pushpop();
    for (int i = 1; i <= 18; i++) begin
      drive_wb(5'(i), 32'h1000 + i, tb_cyc, i <= 16);
      tick();
    end
    idle_wb();
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overflow: got count=%0d full=%b ovf=%0d, required 16 1 2",
               count, full, overflow_cnt);
    end
    out_ready = 1'b1;
    drive_wb(5'd9, 32'h9999_9999, tb_cyc, 1'b1);
    tick();
    idle_wb();
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow_cnt !== 8'd2) begin
      errors++;
      $display("FAIL full_pushpop: got count=%0d full=%b ovf=%0d, required 16 1 2",
               count, full, overflow_cnt);
    end
    drain("overflow");
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: got count=%0d valid=%b, required 0 0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_wb(5'd10, 32'hB0B0_0010, tb_cyc, 1'b1);
    tick();
    checks++;
    if (count !== 5'd1 || out_reg !== 5'd10) begin
      errors++;
      $display("FAIL empty_pushpop: got count=%0d reg=%0d, required 1 10", count, out_reg);
    end
    for (int i = 11; i <= 13; i++) begin
      drive_wb(5'(i), 32'hB0B0_0000 + i, tb_cyc, 1'b1);
      tick();
      checks++;
      if (count !== 5'd1 || out_reg !== 5'(i)) begin
        errors++;
        $display("FAIL stream_pushpop: got count=%0d reg=%0d, required 1 %0d", count, out_reg, i);
      end
    end
    idle_wb();
    drain("back_to_back");
  endtask

  task automatic test_clear_and_reset();
    for (int i = 1; i <= 4; i++) begin
      drive_wb(5'(20 + i), 32'hC000 + i, tb_cyc, 1'b1);
      tick();
    end
    idle_wb();
    checks++;
    if (count !== 5'd4 || overflow_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clear_setup: got count=%0d ovf=%0d, required 4 2", count, overflow_cnt);
    end
    clear = 1'b1;
    drive_wb(5'd3, 32'h3333_3333, tb_cyc, 1'b0);
    tick();
    clear = 1'b0;
    exp_q.delete();
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clear: got count=%0d valid=%b ovf=%0d, required 0 0 0",
               count, out_valid, overflow_cnt);
    end
    drive_wb(5'd4, 32'h4444_0000, 16'd0, 1'b1);
    tick();
    checks++;
    if (out_cycle !== 16'd0 || out_reg !== 5'd4) begin
      errors++;
      $display("FAIL clear_cycle: got cycle=%0d reg=%0d, required 0 4", out_cycle, out_reg);
    end
    for (int i = 1; i <= 2; i++) begin
      drive_wb(5'(4 + i), 32'h4444_0000 + i, tb_cyc, 1'b1);
      tick();
    end
    idle_wb();
    out_ready = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, count, full, overflow_cnt, out_reg, out_data, out_cycle} !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b count=%0d reg=%0d data=%h cycle=%0d, required all 0",
               out_valid, count, out_reg, out_data, out_cycle);
    end
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL post_reset: got valid=%b count=%0d, required 0 0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_filter();
    test_overflow_and_full_pushpop();
    test_back_to_back();
    test_clear_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
